// File: rtl/glitch_pkg.sv
// Shared types and default timing for the clock-glitch sweep controller.
// Delay values are in target clock cycles; timeouts are in fabric clk cycles.
package glitch_pkg;

   typedef logic [31:0] delay_t;

   typedef enum logic [2:0] {
      HARD_RST,
      SOFT_RST,
      WAIT_RST,
      LOAD,
      ARM_TRIG,
      ARM_SUCC,
      DONE
   } state_t;

   localparam delay_t DEF_DELAY_START     = 32'd0;
   localparam delay_t DEF_DELAY_STEP      = 32'd1;
   localparam delay_t DEF_DELAY_MAX       = 32'd1000;
   localparam delay_t DEF_RESET_WAIT      = 32'd4800000;
   localparam delay_t DEF_TRIG_TIMEOUT    = 32'd9600000;
   localparam delay_t DEF_SUCCESS_TIMEOUT = 32'd480000;

   // Next sweep point; wraps to start past the top of the range or on 32-bit carry.
   function automatic delay_t next_delay(input delay_t cur, input delay_t step,
                                         input delay_t start, input delay_t dmax);
      logic [32:0] sum;
      sum = {1'b0, cur} + {1'b0, step};
      if (sum[32] || (sum[31:0] > dmax))
         return start;
      return sum[31:0];
   endfunction

endpackage

// File: rtl/timeout_counter.sv
// Shared 32-bit cycle counter; done goes high once limit cycles have elapsed
// since the last clear. A limit of 0 behaves like 1.
module timeout_counter
   import glitch_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        clear,
   input  logic        enable,
   input  logic [31:0] limit,
   output logic        done
);

   delay_t count;
   delay_t last;

   assign last = (limit == 32'd0) ? 32'd0 : limit - 32'd1;
   assign done = (count >= last);

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst)
         count <= '0;
      else if (clear)
         count <= '0;
      else if (enable && !done)
         count <= count + 32'd1;
   end

endmodule

// File: rtl/glitch_sweep_controller.sv
// Sweep sequencer: reset target, load delay, wait for trigger, wait for success,
// then step the delay and retry until the glitch lands.
module glitch_sweep_controller
   import glitch_pkg::*;
#(
   parameter logic [31:0] DELAY_START     = DEF_DELAY_START,
   parameter logic [31:0] DELAY_STEP      = DEF_DELAY_STEP,
   parameter logic [31:0] DELAY_MAX       = DEF_DELAY_MAX,
   parameter logic [31:0] RESET_WAIT      = DEF_RESET_WAIT,
   parameter logic [31:0] TRIG_TIMEOUT    = DEF_TRIG_TIMEOUT,
   parameter logic [31:0] SUCCESS_TIMEOUT = DEF_SUCCESS_TIMEOUT
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        trigger,
   input  logic        success,
   output logic [31:0] delay,
   output logic        set_delay,
   output logic        trigger_arm,
   output logic        success_arm,
   output logic        target_soft_reset,
   output logic        target_hard_reset,
   output logic        found
);

   state_t      state;
   logic [31:0] limit;
   logic        cnt_clear;
   logic        cnt_enable;
   logic        cnt_done;

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      limit      = SUCCESS_TIMEOUT;
      cnt_enable = state inside {WAIT_RST, ARM_TRIG, ARM_SUCC};
      cnt_clear  = !cnt_enable || ((state == ARM_TRIG) && trigger);
      case (state)
         WAIT_RST: limit = RESET_WAIT;
         ARM_TRIG: limit = TRIG_TIMEOUT;
         default:  limit = SUCCESS_TIMEOUT;
      endcase
   end

   timeout_counter u_timeout (
      .clk    (clk),
      .rst    (rst),
      .clear  (cnt_clear),
      .enable (cnt_enable),
      .limit  (limit),
      .done   (cnt_done)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         state             <= HARD_RST;
         delay             <= DELAY_START;
         set_delay         <= 1'b0;
         trigger_arm       <= 1'b0;
         success_arm       <= 1'b0;
         target_soft_reset <= 1'b0;
         target_hard_reset <= 1'b0;
         found             <= 1'b0;
      end else begin
         // Outputs mirror the state one cycle late, so they rise after entry and fall after exit.
         set_delay         <= (state == LOAD);
         trigger_arm       <= (state == ARM_TRIG);
         success_arm       <= (state == ARM_SUCC);
         target_soft_reset <= (state == SOFT_RST);
         target_hard_reset <= (state == HARD_RST);
         found             <= found | (state == DONE);

         case (state)
            HARD_RST, SOFT_RST: state <= WAIT_RST;
            WAIT_RST:           if (cnt_done) state <= LOAD;
            LOAD:               state <= ARM_TRIG;
            ARM_TRIG: begin
               if (trigger)
                  state <= ARM_SUCC;
               else if (cnt_done)
                  state <= HARD_RST;
            end
            ARM_SUCC: begin
               if (success)
                  state <= DONE;
               else if (cnt_done) begin
                  delay <= next_delay(delay, DELAY_STEP, DELAY_START, DELAY_MAX);
                  state <= SOFT_RST;
               end
            end
            DONE:               state <= DONE;
            default:            state <= HARD_RST;
         endcase
      end
   end

endmodule

// File: tb/tb_glitch_sweep_controller.sv
// Directed bench for glitch_sweep_controller with short timeouts and a small sweep range.
module tb_glitch_sweep_controller;

   localparam int SEL_SET  = 0;
   localparam int SEL_SOFT = 1;
   localparam int SEL_HARD = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        trigger = 1'b0;
   logic        success = 1'b0;
   logic [31:0] delay;
   logic        set_delay;
   logic        trigger_arm;
   logic        success_arm;
   logic        target_soft_reset;
   logic        target_hard_reset;
   logic        found;

   int vectors     = 0;
   int miscompares = 0;
   int n;

   always #5 clk = ~clk;

   glitch_sweep_controller #(
      .DELAY_START     (32'd0),
      .DELAY_STEP      (32'd1),
      .DELAY_MAX       (32'd5),
      .RESET_WAIT      (32'd10),
      .TRIG_TIMEOUT    (32'd30),
      .SUCCESS_TIMEOUT (32'd20)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .trigger           (trigger),
      .success           (success),
      .delay             (delay),
      .set_delay         (set_delay),
      .trigger_arm       (trigger_arm),
      .success_arm       (success_arm),
      .target_soft_reset (target_soft_reset),
      .target_hard_reset (target_hard_reset),
      .found             (found)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic logic sig(input int which);
      case (which)
         SEL_SET:  return set_delay;
         SEL_SOFT: return target_soft_reset;
         default:  return target_hard_reset;
      endcase
   endfunction

   // Ticks until the selected output is high; n = ticks taken, or -1 if the budget runs out.
   task automatic wait_for(input int which, input int budget, output int cycles);
      cycles = -1;
      for (int i = 1; i <= budget; i++) begin
         tick();
         if (sig(which)) begin
            cycles = i;
            break;
         end
      end
   endtask

   // Entered just after the edge that raised a target reset pulse.
   // Pulse lasts one cycle; WAIT_RST then spans 10 cycles, LOAD 1, set_delay follows.
   task automatic after_hard(input logic [31:0] exp_delay);
      int c;
      tick();
      check("rst_pulse_width", {31'd0, target_hard_reset | target_soft_reset}, 32'd0);
      wait_for(SEL_SET, 100, c);
      check("rst_to_set_delay", c, 32'd10);
      check("load_delay", delay, exp_delay);
   endtask

   task automatic startup(input logic [31:0] exp_delay);
      tick();
      check("hard_after_release", {31'd0, target_hard_reset}, 32'd1);
      after_hard(exp_delay);
   endtask

   // Entered just after set_delay edge S; trigger is sampled at S+3 (held two cycles).
   task automatic do_trigger();
      tick();
      tick();
      trigger = 1'b1;
      tick();
      check("succ_arm_not_yet", {31'd0, success_arm}, 32'd0);
      tick();
      check("succ_arm_rise", {31'd0, success_arm}, 32'd1);
      check("trig_arm_fall", {31'd0, trigger_arm}, 32'd0);
      trigger = 1'b0;
   endtask

   // ARM_SUCC lasts 20 cycles, soft reset appears as success_arm drops.
   task automatic fail_attempt(input logic [31:0] now_d, input logic [31:0] next_d);
      int c;
      check("attempt_delay", delay, now_d);
      do_trigger();
      wait_for(SEL_SOFT, 100, c);
      check("succ_timeout_cycles", c, 32'd20);
      check("succ_arm_after_timeout", {31'd0, success_arm}, 32'd0);
      check("no_hard_on_soft", {31'd0, target_hard_reset}, 32'd0);
      check("advanced_delay", delay, next_d);
      after_hard(next_d);
   endtask

   initial begin
      // Reset state
      repeat (3) tick();
      check("rst_delay", delay, 32'd0);
      check("rst_set_delay", {31'd0, set_delay}, 32'd0);
      check("rst_trig_arm", {31'd0, trigger_arm}, 32'd0);
      check("rst_succ_arm", {31'd0, success_arm}, 32'd0);
      check("rst_soft", {31'd0, target_soft_reset}, 32'd0);
      check("rst_hard", {31'd0, target_hard_reset}, 32'd0);
      check("rst_found", {31'd0, found}, 32'd0);

      rst = 1'b1;
      startup(32'd0);
      tick();
      check("trig_arm_rise", {31'd0, trigger_arm}, 32'd1);

      // No trigger: 30 cycles of trigger_arm, then a hard reset, delay kept
      wait_for(SEL_HARD, 100, n);
      check("trig_timeout_cycles", n, 32'd30);
      check("trig_arm_after_timeout", {31'd0, trigger_arm}, 32'd0);
      check("delay_kept_on_hard", delay, 32'd0);
      after_hard(32'd0);

      // Failed attempts: 0..5 then wrap to 0, then back up to 5
      for (int i = 0; i < 11; i++)
         fail_attempt(i % 6, (i + 1) % 6);

      // Mid-run reset during ARM_SUCC at delay 5
      check("pre_reset_delay", delay, 32'd5);
      do_trigger();
      tick();
      rst = 1'b0;
      tick();
      check("midrst_delay", delay, 32'd0);
      check("midrst_found", {31'd0, found}, 32'd0);
      check("midrst_succ_arm", {31'd0, success_arm}, 32'd0);
      tick();
      rst = 1'b1;
      startup(32'd0);

      // Trigger, then success sampled 5 cycles after trigger (held two cycles)
      do_trigger();
      repeat (3) tick();
      success = 1'b1;
      tick();
      check("found_not_yet", {31'd0, found}, 32'd0);
      tick();
      success = 1'b0;
      check("found_set", {31'd0, found}, 32'd1);
      check("done_succ_arm", {31'd0, success_arm}, 32'd0);
      check("done_trig_arm", {31'd0, trigger_arm}, 32'd0);
      check("done_delay", delay, 32'd0);
      trigger = 1'b1;
      repeat (40) tick();
      trigger = 1'b0;
      check("found_sticky", {31'd0, found}, 32'd1);
      check("done_ignores_trigger", {31'd0, trigger_arm}, 32'd0);
      check("done_no_hard", {31'd0, target_hard_reset}, 32'd0);

      // Success on the same cycle as the success timeout, at delay 1
      rst = 1'b0;
      repeat (2) tick();
      rst = 1'b1;
      startup(32'd0);
      fail_attempt(32'd0, 32'd1);
      do_trigger();
      repeat (18) tick();
      success = 1'b1;
      tick();
      success = 1'b0;
      tick();
      check("tie_no_soft", {31'd0, target_soft_reset}, 32'd0);
      check("tie_found", {31'd0, found}, 32'd1);
      check("tie_delay", delay, 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
